mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl_pkg.sv | 23 ++
 rtl/mac_seq_dp.sv | 56 +++++
 rtl/mac_seq_ctrl.sv | 94 +++++++++
 tb/tb_mac_seq_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and constants for the sequential MAC controller.
// Saturation bound helpers are used by the datapath when MAC_SAT_EN is defined.
package mac_seq_ctrl_pkg;

    localparam int ACCW_DEFAULT = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Largest positive value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a w-bit two's-complement word.
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/mac_seq_dp.sv
// MAC datapath: signed multiply, sign-extend, add and accumulator register.
// Define MAC_SAT_EN to clamp each accumulate instead of wrapping modulo 2^ACCW.
module mac_seq_dp
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int ACCW   = ACCW_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic signed [ACCW-1:0]   load_val,
    input  logic                     en,
    input  logic signed [DWIDTH-1:0] a,
    input  logic signed [DWIDTH-1:0] b,
    output logic signed [ACCW-1:0]   acc
);

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [ACCW-1:0]     prod_ext;
    logic signed [ACCW-1:0]     acc_reg;
    logic signed [ACCW-1:0]     acc_next;

    assign prod     = $signed({{DWIDTH{a[DWIDTH-1]}}, a}) * $signed({{DWIDTH{b[DWIDTH-1]}}, b});
    assign prod_ext = ACCW'(prod);

`ifdef MAC_SAT_EN
    localparam logic signed [ACCW-1:0] ACC_MAX = ACCW'(sat_max(ACCW));
    localparam logic signed [ACCW-1:0] ACC_MIN = ACCW'(sat_min(ACCW));

    logic signed [ACCW:0] sum_wide;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    assign sum_wide = {acc_reg[ACCW-1], acc_reg} + {prod_ext[ACCW-1], prod_ext};

    always_comb begin
        acc_next = sum_wide[ACCW-1:0];
        if (sum_wide[ACCW] != sum_wide[ACCW-1])
            acc_next = sum_wide[ACCW] ? ACC_MIN : ACC_MAX;
    end
`else
    assign acc_next = acc_reg + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_reg <= '0;
        else if (load)
            acc_reg <= load_val;
        else if (en)
            acc_reg <= acc_next;
    end

    assign acc = acc_reg;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequential dot-product controller: FSM, beat counter and valid/ready handshakes.
// The MAC_SAT_EN macro selects saturating accumulation inside mac_seq_dp.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int ACCW   = ACCW_DEFAULT,
    parameter int LENW   = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LENW-1:0]          cfg_len,
    input  logic signed [ACCW-1:0]   cfg_bias,
    output logic                     busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DWIDTH-1:0] in_a,
    input  logic signed [DWIDTH-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACCW-1:0]   out_data
);

    state_t          state_reg, state_next;
    logic [LENW-1:0] cnt_reg, cnt_next;
    logic [LENW-1:0] len_reg, len_next;
    logic            acc_load;
    logic            beat;
    logic signed [ACCW-1:0] acc;

    assign acc_load = (state_reg == ST_IDLE) && start;
    assign beat     = (state_reg == ST_ACC) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            len_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            len_reg   <= len_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        busy       = (state_reg != ST_IDLE);
        in_ready   = (state_reg == ST_ACC);
        out_valid  = (state_reg == ST_OUT);
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cnt_next = '0;
                    len_next = cfg_len;
                    // A zero-length request skips accumulation; the bias is the result.
                    state_next = (cfg_len != '0) ? ST_ACC : ST_OUT;
                end
            end
            ST_ACC: begin
                if (in_valid) begin
                    cnt_next = cnt_reg + LENW'(1);
                    if (cnt_reg == len_reg - LENW'(1))
                        state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    mac_seq_dp #(
        .DWIDTH (DWIDTH),
        .ACCW   (ACCW)
    ) u_dp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc_load),
        .load_val (cfg_bias),
        .en       (beat),
        .a        (in_a),
        .b        (in_b),
        .acc      (acc)
    );

    assign out_data = acc;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed self-checking bench for mac_seq_ctrl (ACCW=16 so the overflow case is reachable).
// Expected overflow result follows MAC_SAT_EN when the bench is built with it.
module tb_mac_seq_ctrl;

    localparam int DWIDTH = 8;
    localparam int ACCW   = 16;
    localparam int LENW   = 10;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [LENW-1:0]          cfg_len;
    logic signed [ACCW-1:0]   cfg_bias;
    logic                     busy;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] in_a;
    logic signed [DWIDTH-1:0] in_b;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACCW-1:0]   out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac_seq_ctrl #(
        .DWIDTH (DWIDTH),
        .ACCW   (ACCW),
        .LENW   (LENW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int a, input int b);
        in_valid = 1'b1;
        in_a     = DWIDTH'(a);
        in_b     = DWIDTH'(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic go(input int len, input int bias);
        start    = 1'b1;
        cfg_len  = LENW'(len);
        cfg_bias = ACCW'(bias);
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("drain_ovalid", 32'(out_valid), 0);
        chk("drain_busy", 32'(busy), 0);
    endtask

    int exp_ovf;

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_bias = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Dot product: 10 + 6 - 20 - 7 = -11
        go(3, 10);
        chk("dp_busy", 32'(busy), 1);
        chk("dp_in_ready", 32'(in_ready), 1);
        beat(2, 3);
        beat(-4, 5);
        chk("dp_ov_early", 32'(out_valid), 0);
        beat(7, -1);
        chk("dp_out_valid", 32'(out_valid), 1);
        chk("dp_out_data", 32'(out_data), -11);

        // Back-pressure with an ignored start
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1; cfg_len = LENW'(2); cfg_bias = ACCW'(99);
            end else begin
                start = 1'b0;
            end
            tick();
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_out_data", 32'(out_data), -11);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        start = 1'b0;
        drain();

        // Zero length
        go(0, -5);
        chk("z_out_valid", 32'(out_valid), 1);
        chk("z_out_data", 32'(out_data), -5);
        chk("z_in_ready", 32'(in_ready), 0);
        drain();

        // Gapped input: 2 + 12 - 30 + 64 = 48
        go(4, 0);
        beat(1, 2);   tick();
        beat(3, 4);   tick();
        beat(-5, 6);  tick();
        chk("g_busy_acc", 32'(in_ready), 1);
        chk("g_ov_pending", 32'(out_valid), 0);
        beat(8, 8);
        chk("g_out_valid", 32'(out_valid), 1);
        chk("g_out_data", 32'(out_data), 48);
        drain();

        // Overflow at ACCW=16
`ifdef MAC_SAT_EN
        exp_ovf = 32767;
`else
        exp_ovf = -32768;
`endif
        go(1, 32767);
        beat(1, 1);
        chk("ovf_out_valid", 32'(out_valid), 1);
        chk("ovf_out_data", 32'(out_data), exp_ovf);
        drain();

        // Reset mid-ACC after two beats
        go(4, 100);
        beat(10, 10);
        beat(10, 10);
        chk("mr_busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_in_ready", 32'(in_ready), 0);
        chk("mr_out_valid", 32'(out_valid), 0);
        chk("mr_out_data", 32'(out_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        go(1, 7);
        beat(2, 3);
        chk("mr_fresh_ov", 32'(out_valid), 1);
        chk("mr_fresh_data", 32'(out_data), 13);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
